// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  localparam int DIV_W = 16;

  // Rounded CLK_FREQ / (16 * baud).
  function automatic logic [DIV_W-1:0] os_div(input int clk_freq, input logic [1:0] baud_code);
    int baud;
    case (baud_code)
      BAUD_2400: baud = 2400;
      BAUD_4800: baud = 4800;
      BAUD_9600: baud = 9600;
      default:   baud = 19200;
    endcase
    return DIV_W'((clk_freq + 8 * baud) / (16 * baud));
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-cycle tick every div cycles; restart re-aligns the phase.
// No backpressure; tick is combinational from the counter state.
module uart_os_tick_gen
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver with 2-FF synchronizer and 3-sample majority vote per bit.
// Latency: done ~((1+DATA_BITS+P)*16+9) ticks after start edge plus 2 sync cycles; no backpressure.
module uart_rx_os16
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [1:0]           baud_rate,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_active_flag,
  output logic                 rx_done_flag,
  output logic [2:0]           error_flag
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [DIV_W-1:0] DIV_2400  = os_div(CLK_FREQ, BAUD_2400);
  localparam logic [DIV_W-1:0] DIV_4800  = os_div(CLK_FREQ, BAUD_4800);
  localparam logic [DIV_W-1:0] DIV_9600  = os_div(CLK_FREQ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_19200 = os_div(CLK_FREQ, BAUD_19200);

  rx_state_t            state, next_state;
  logic                 rx_meta, rx_s, rx_s_d;
  logic                 start_edge, tick, vote, par_en;
  logic [3:0]           scnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_err;
  logic [1:0]           baud_q, par_q;
  logic [DIV_W-1:0]     div;

  // Presetting the synchronizer high keeps reset from looking like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_s_d && !rx_s;
  assign vote       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign par_en     = (par_q == PAR_ODD) || (par_q == PAR_EVEN);

  always_comb begin
    case (baud_q)
      BAUD_2400: div = DIV_2400;
      BAUD_4800: div = DIV_4800;
      BAUD_9600: div = DIV_9600;
      default:   div = DIV_19200;
    endcase
  end

  uart_os_tick_gen u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .div     (div),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge) next_state = START;
      START: begin
        if (tick && scnt == 4'd9 && vote) next_state = IDLE;
        else if (tick && scnt == 4'd15)   next_state = DATA;
      end
      DATA:    if (tick && scnt == 4'd15 && bit_cnt == LAST_BIT) next_state = par_en ? PARITY : STOP;
      PARITY:  if (tick && scnt == 4'd15) next_state = STOP;
      STOP:    if (tick && scnt == 4'd9)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_active_flag = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      rx_done_flag <= 1'b0;
      error_flag   <= '0;
      scnt         <= '0;
      bit_cnt      <= '0;
      samp         <= '0;
      shreg        <= '0;
      parity_err   <= 1'b0;
      baud_q       <= BAUD_2400;
      par_q        <= PAR_NONE;
    end else begin
      rx_done_flag <= 1'b0;
      if (start_edge) begin
        scnt       <= '0;
        bit_cnt    <= '0;
        parity_err <= 1'b0;
        error_flag <= '0;
        baud_q     <= baud_rate;
        par_q      <= parity_type;
      end else if (tick && state != IDLE) begin
        scnt <= scnt + 1'b1;
        if (scnt == 4'd7) samp[0] <= rx_s;
        if (scnt == 4'd8) samp[1] <= rx_s;
        case (state)
          START:  if (scnt == 4'd9 && vote) error_flag[ERR_START] <= 1'b1;
          DATA: begin
            if (scnt == 4'd9)  shreg   <= {vote, shreg[DATA_BITS-1:1]};
            if (scnt == 4'd15) bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: if (scnt == 4'd9) parity_err <= (vote != ((par_q == PAR_ODD) ? ~^shreg : ^shreg));
          STOP: begin
            if (scnt == 4'd9) begin
              data_out               <= shreg;
              error_flag[ERR_STOP]   <= ~vote;
              error_flag[ERR_START]  <= 1'b0;
              error_flag[ERR_PARITY] <= parity_err;
              rx_done_flag           <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
